// File: rtl/gon_pkg.sv
// gon_pkg: shared types and constants for the GON network stages.
//   drain_state_e            : psum drain controller states
//   DRAIN_FIFO_DEPTH_DEFAULT : default elastic buffer depth for the drain
//   psum_t                   : one psum word as carried on the gather bus
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
package gon_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} drain_state_e;
   localparam int DRAIN_FIFO_DEPTH_DEFAULT = 4;
   typedef logic [`DATA_BITS-1:0] psum_t;
endpackage

// File: rtl/gon_sync_fifo.sv
// gon_sync_fifo: small synchronous FIFO with registered storage, no bypass.
//   clk, rst (async, active-low) ; push/din write ; pop read
//   full, empty status ; head = oldest entry (valid when !empty)
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
module gon_sync_fifo #(
   parameter int DATA_BITS  = `DATA_BITS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] din,
   output logic                 full,
   output logic                 empty,
   output logic [DATA_BITS-1:0] head
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic do_push, do_pop;
   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty   = wr_q == rd_q;
   assign head    = mem_q[rd_q[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   always_comb begin
      wr_d = wr_q + PW'(do_push);
      rd_d = rd_q + PW'(do_pop);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/gon_psum_drain.sv
// gon_psum_drain: drains the merged GON gather stream into the GLB.
//   start/base_addr/total_words : launch one pass (IDLE only)
//   in_valid/in_ready/in_data   : gather bus slave side
//   glb_we/glb_addr/glb_wdata/glb_ready : GLB write port
//   busy (RUN/DRAIN), done (one-cycle pulse at pass end)
//   clk, rst (async, active-low)
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
module gon_psum_drain
   import gon_pkg::*;
#(
   parameter int DATA_BITS  = `DATA_BITS,
   parameter int ADDR_BITS  = 32,
   parameter int CNT_BITS   = 16,
   parameter int FIFO_DEPTH = DRAIN_FIFO_DEPTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [CNT_BITS-1:0]  total_words,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 in_ready,
   output logic                 glb_we,
   output logic [ADDR_BITS-1:0] glb_addr,
   output logic [DATA_BITS-1:0] glb_wdata,
   input  logic                 glb_ready,
   output logic                 busy,
   output logic                 done
);
   drain_state_e state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [CNT_BITS-1:0]  accept_left_q, accept_left_d, write_left_q, write_left_d;
   logic fifo_full, fifo_empty, push, wr_done, active;
   logic [DATA_BITS-1:0] head;
   assign active    = (state_q == RUN) || (state_q == DRAIN);
   // in_ready looks only at full, never at this cycle's pop or at in_valid.
   assign in_ready  = (state_q == RUN) && !fifo_full && (accept_left_q != '0);
   assign glb_we    = active && !fifo_empty;
   assign glb_addr  = addr_q;
   assign glb_wdata = glb_we ? head : '0;
   assign busy      = active;
   assign done      = state_q == DONE;
   assign push      = in_valid && in_ready;
   assign wr_done   = glb_we && glb_ready;
   gon_sync_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(wr_done), .din(in_data),
      .full(fifo_full), .empty(fifo_empty), .head(head)
   );
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q + ADDR_BITS'(wr_done);
      accept_left_d = accept_left_q - CNT_BITS'(push);
      write_left_d  = write_left_q - CNT_BITS'(wr_done && (write_left_q != '0));
      case (state_q)
         IDLE: if (start) begin
            addr_d        = base_addr;
            accept_left_d = total_words;
            write_left_d  = total_words;
            state_d       = (total_words == '0) ? DONE : RUN;
         end
         // The final write moves straight to DONE so done lands the cycle after it.
         RUN:   state_d = (write_left_d == '0) ? DONE : (accept_left_d == '0) ? DRAIN : RUN;
         DRAIN: state_d = (write_left_d == '0) ? DONE : DRAIN;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         accept_left_q <= '0;
         write_left_q  <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         accept_left_q <= accept_left_d;
         write_left_q  <= write_left_d;
      end
   end
endmodule

// File: tb/tb_gon_psum_drain.sv
// tb_gon_psum_drain: directed table plus multi-cycle sequences for gon_psum_drain.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
module tb_gon_psum_drain;
   localparam int DB = `DATA_BITS;
   logic clk = 0, rst = 0, start = 0, in_valid = 0, glb_ready = 0;
   logic [31:0] base_addr = '0;
   logic [15:0] total_words = '0;
   logic [DB-1:0] in_data = '0;
   logic in_ready, glb_we, busy, done;
   logic [31:0] glb_addr;
   logic [DB-1:0] glb_wdata;
   always #5 clk = ~clk;
   gon_psum_drain dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_words(total_words),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .glb_we(glb_we),
      .glb_addr(glb_addr), .glb_wdata(glb_wdata), .glb_ready(glb_ready), .busy(busy), .done(done)
   );
   int nvec = 0, errs = 0;
   logic [31:0] wa[$], wd[$];
   int wc[$], ac[$];
   int done_cnt, done_cyc, sent;
   bit any_ir, any_we;
   typedef struct {
      logic st; logic iv; logic [31:0] id;
      logic ir; logic we; logic [31:0] ad; logic [31:0] wdat; logic bz; logic dn;
   } vec_t;
   vec_t tbl[8];
   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic run_pass(input logic [31:0] base, input logic [15:0] total, input int offer,
                           input int stall, input bit mid_start, input int abort_after);
      bit pw = 0, pr = 1, fin = 0;
      logic [31:0] pa = '0, pd = '0;
      wa.delete(); wd.delete(); wc.delete(); ac.delete();
      done_cnt = 0; done_cyc = -1; sent = 0; any_ir = 0; any_we = 0;
      for (int c = 0; c < 300 && !fin; c++) begin
         @(posedge clk); #1;
         start       = (c == 0) || (mid_start && c == 3);
         base_addr   = (c == 0) ? base : 32'h55;
         total_words = (c == 0) ? total : 16'd9;
         in_valid    = sent < offer;
         in_data     = DB'(sent + 1);
         glb_ready   = c > stall;
         @(negedge clk);
         if (in_ready) any_ir = 1;
         if (glb_we) any_we = 1;
         if (pw && !pr) chk("stall_hold", {glb_we, glb_addr, 32'(glb_wdata)}, {1'b1, pa, pd});
         pw = glb_we; pr = glb_ready; pa = glb_addr; pd = 32'(glb_wdata);
         if (stall > 0 && c == stall) chk("fill_full", {in_ready, 32'(sent)}, {1'b0, 32'd4});
         if (in_valid && in_ready) begin sent++; ac.push_back(c); end
         if (glb_we && glb_ready) begin
            wa.push_back(glb_addr); wd.push_back(32'(glb_wdata)); wc.push_back(c);
         end
         if (done) begin done_cnt++; done_cyc = c; end
         if (abort_after > 0 && wa.size() == abort_after) begin
            @(posedge clk); #1 rst = 0; #1;
            chk("abort_outs", {in_ready, glb_we, busy, done, glb_addr, 32'(glb_wdata)}, '0);
            start = 0; in_valid = 0;
            repeat (3) begin @(negedge clk); if (done) done_cnt++; end
            @(posedge clk); #1 rst = 1;
            fin = 1;
         end
         if (done_cyc >= 0 && c >= done_cyc + 2) fin = 1;
      end
      start = 0; in_valid = 0; glb_ready = 0;
      if (!fin) chk("pass_timeout", 0, 1);
   endtask
   task automatic check_writes(input string nm, input logic [31:0] base, input int n);
      chk({nm, "_count"}, 32'(wa.size()), 32'(n));
      if (wa.size() == n)
         for (int i = 0; i < n; i++) chk({nm, "_write"}, {wa[i], wd[i]}, {base + 32'(i), 32'(i + 1)});
      chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
   endtask
   initial begin
      tbl[0] = '{1, 1, 32'd1, 0, 0, 32'h0,   32'd0, 0, 0};
      tbl[1] = '{0, 1, 32'd1, 1, 0, 32'h100, 32'd0, 1, 0};
      tbl[2] = '{0, 1, 32'd2, 1, 1, 32'h100, 32'd1, 1, 0};
      tbl[3] = '{0, 1, 32'd3, 1, 1, 32'h101, 32'd2, 1, 0};
      tbl[4] = '{0, 1, 32'd4, 1, 1, 32'h102, 32'd3, 1, 0};
      tbl[5] = '{0, 1, 32'd5, 0, 1, 32'h103, 32'd4, 1, 0};
      tbl[6] = '{0, 0, 32'd0, 0, 0, 32'h104, 32'd0, 0, 1};
      tbl[7] = '{0, 0, 32'd0, 0, 0, 32'h104, 32'd0, 0, 0};
      #2 chk("reset_outs", {in_ready, glb_we, busy, done, glb_addr, 32'(glb_wdata)}, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      // Four-word pass, cycle by cycle, GLB always ready.
      glb_ready = 1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         start = tbl[i].st; base_addr = 32'h100; total_words = 16'd4;
         in_valid = tbl[i].iv; in_data = DB'(tbl[i].id);
         @(negedge clk);
         chk($sformatf("table_row%0d", i),
             {in_ready, glb_we, glb_addr, 32'(glb_wdata), busy, done},
             {tbl[i].ir, tbl[i].we, tbl[i].ad, tbl[i].wdat, tbl[i].bz, tbl[i].dn});
      end
      start = 0; in_valid = 0;
      // Basic 8-word pass: latency, throughput, done timing.
      run_pass(32'h100, 16'd8, 8, 0, 0, 0);
      check_writes("basic", 32'h100, 8);
      if (wc.size() == 8 && ac.size() == 8) begin
         chk("basic_latency", 32'(wc[0] - ac[0]), 32'd1);
         chk("basic_tput", 32'(wc[7] - wc[0]), 32'd7);
         chk("basic_done_at", 32'(done_cyc - wc[7]), 32'd1);
      end
      // GLB backpressure fills the FIFO.
      run_pass(32'h400, 16'd6, 6, 5, 0, 0);
      check_writes("backpr", 32'h400, 6);
      // Zero length.
      run_pass(32'h800, 16'd0, 0, 0, 0, 0);
      chk("zero_done_at", 32'(done_cyc), 32'd1);
      chk("zero_quiet", {any_ir, any_we, 32'(done_cnt)}, {1'b0, 1'b0, 32'd1});
      // Over-supply: only total_words accepted.
      run_pass(32'hA00, 16'd3, 5, 0, 0, 0);
      chk("over_sent", 32'(sent), 32'd3);
      check_writes("over", 32'hA00, 3);
      // Address wrap with an ignored mid-pass start.
      run_pass(32'hFFFF_FFFE, 16'd4, 4, 0, 1, 0);
      check_writes("wrap", 32'hFFFF_FFFE, 4);
      // Reset mid-pass, then a clean restart.
      run_pass(32'h300, 16'd8, 8, 0, 0, 2);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      run_pass(32'h2000, 16'd2, 2, 0, 0, 0);
      check_writes("restart", 32'h2000, 2);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end
endmodule

// File: doc/gon_psum_drain.md
Name: gon_psum_drain

Overview:
- Consumer stage directly downstream of the GON gather bus.
- Accepts the bus's single merged psum stream (valid/ready/data) into a small elastic FIFO.
- Writes each word to the global buffer (GLB) at consecutive word addresses from a configured base, for a configured word count.
- Signals done once the final word is written, so the controller can start the next pass.

Parameters:
- DATA_BITS, `DATA_BITS, width of one psum word on the bus and the GLB write port.
- ADDR_BITS, 32, GLB word-address width.
- CNT_BITS, 16, width of the transfer-length counter.
- FIFO_DEPTH, 4, elastic buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that launches one drain pass; honoured only in IDLE.
- base_addr  input  ADDR_BITS  first GLB word address; sampled on accepted start.
- total_words  input  CNT_BITS  number of words in the pass; sampled on accepted start.
- in_valid  input  1  gather bus has a word (bus slave_valid).
- in_data  input  DATA_BITS  word from the gather bus.
- in_ready  output  1  block accepts the word this cycle (drives bus slave_ready).
- glb_we  output  1  GLB write request.
- glb_addr  output  ADDR_BITS  GLB write word address.
- glb_wdata  output  DATA_BITS  GLB write data.
- glb_ready  input  1  GLB accepts the write this cycle.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; FIFO emptied; all counters and address cleared. Outputs in_ready, glb_we, busy and done are 0; glb_addr and glb_wdata are 0.
- States:
  - IDLE: in_ready=0, glb_we=0.
    - start=1 with total_words!=0: latch base_addr into the address register, total_words into both remaining counters; go to RUN.
    - start=1 with total_words==0: go to DONE.
  - RUN: in_ready = !fifo_full && (accept_left!=0).
    - Push when in_valid && in_ready; accept_left decrements.
    - Go to DRAIN when accept_left reaches 0.
  - DRAIN: in_ready=0; FIFO continues to empty.
  - Write-side rule (RUN and DRAIN):
    - glb_we = !fifo_empty; glb_wdata = FIFO head; glb_addr = address register.
    - A write completes when glb_we && glb_ready: pop FIFO, address +1, write_left decrements.
  - Completion: leave RUN or DRAIN for DONE in the cycle after write_left reaches 0.
  - DONE: done=1 for exactly one cycle, busy=0; then IDLE.
- Handshakes:
  - glb_we, glb_addr and glb_wdata hold stable while glb_we=1 && glb_ready=0.
  - in_ready is not combinationally dependent on in_valid.
- Latency:
  - A word accepted in cycle N appears on glb_we/glb_wdata in cycle N+1 at the earliest. No same-cycle bypass.
  - With glb_ready held high, sustained throughput is 1 word per cycle.
- FIFO:
  - in_ready depends only on fifo_full, not on a same-cycle pop. A full FIFO refuses input even if it pops that cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Arithmetic:
  - The address register wraps modulo 2^ADDR_BITS; no error flag.
  - Counters never underflow; decrements are gated by !=0.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid while in IDLE, DRAIN or DONE is not accepted.
  - rst low mid-pass aborts the pass: no done pulse, FIFO contents discarded.

Decomposition:
- Shared package gon_pkg:
  - typedef enum of drain states (IDLE, RUN, DRAIN, DONE).
  - DRAIN_FIFO_DEPTH_DEFAULT constant.
  - Typedef for the psum word built on `DATA_BITS.
- One natural sub-module: gon_sync_fifo.
  - Parameterised DATA_BITS and FIFO_DEPTH.
  - Ports: push, pop, full, empty, head; same clk/rst convention.
  - Reusable by other network stages.

Test Plan:
- Basic pass, glb_ready=1: start with base_addr=0x100, total_words=8, in_valid=1, data 1..8 → writes 1..8 to 0x100..0x107, one per cycle. First glb_we comes 1 cycle after the first accept. done pulses once, the cycle after the 8th write.
- GLB backpressure: total_words=6, glb_ready low for 5 cycles at start → FIFO fills to 4 and in_ready drops. glb_addr and glb_wdata stay stable while stalled. All 6 words are written in order, none lost or duplicated.
- Zero length: start with total_words=0 → DONE next cycle, done=1 for 1 cycle. in_ready and glb_we never assert.
- Over-supply: total_words=3, bus offers 5 words → exactly 3 accepted, then in_ready=0 in DRAIN. Words 4 and 5 stay pending on the bus.
- Address wrap and start ignore: base_addr=0xFFFFFFFE, total_words=4 → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. A start pulse mid-pass has no effect.
- Reset mid-pass: rst driven low after 2 of 8 writes → outputs 0 immediately (async), no done. A subsequent start with total_words=2 runs cleanly from the new base_addr.
